trap_controller: RTL and testbench

Sequences machine-mode interrupt entry and `mret` exit around the CSR register file and the pipeline. It arbitrates the timer and external interrupt sources against the `mie`/`mstatus.MIE` enables, then stalls fetch and waits for a commit point. It captures the trap PC and cause, issues the CSR update strobes, and performs a single-cycle flush plus PC redirect. It sits between the commit stage, the CSR register file and the fetch unit.

---
 rtl/trap_controller.sv | 156 +++++++++++++++
 tb/tb_trap_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates timer/external interrupts, drains the
// pipeline to a commit point, then issues CSR strobes, flush and PC redirect.
module trap_controller #(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            irq_timer,
    input  logic            irq_ext,
    input  logic            mie_mtie,
    input  logic            mie_meie,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_q,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_mret,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            stall_req,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_we,
    output logic [XLEN-1:0] mepc_wdata,
    output logic [XLEN-1:0] mcause_wdata,
    output logic            mstatus_trap,
    output logic            mstatus_mret,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_TRAP  = 2'd2;
    localparam logic [1:0] ST_MRET  = 2'd3;
    localparam logic [7:0] DRAIN_LIMIT = 8'(DRAIN_MAX);

    logic [1:0]      rst_sync_q;
    logic            rst_n_s;
    logic [1:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic [XLEN-1:0] mepc_wdata_q, mepc_wdata_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    logic            pending_s;
    logic            ext_win_s;
    logic [3:0]      code_s;
    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] cause_s;
    logic [XLEN-1:0] trap_pc_s;

    // Reset synchronizer: assertion is immediate, release waits two clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    assign ext_win_s = irq_ext & mie_meie;
    assign pending_s = mstatus_mie & (ext_win_s | (irq_timer & mie_mtie));
    assign code_s    = ext_win_s ? 4'd11 : 4'd7;
    assign cause_s   = {1'b1, {(XLEN-5){1'b0}}, code_s};
    assign base_s    = {mtvec[XLEN-1:2], 2'b00};
    assign trap_pc_s = commit_valid ? commit_pc : fetch_pc;

    // Trap vector: vectored mode offsets by 4*code, every other mode jumps to base.
    always_comb begin
        target_s = base_s;
        if (mtvec[1:0] == 2'b01) begin
            target_s = base_s + {{(XLEN-6){1'b0}}, code_s, 2'b00};
        end else begin
            target_s = base_s;
        end
    end

    // Next-state and latch-data selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        redirect_d   = redirect_q;
        mepc_wdata_d = mepc_wdata_q;
        mcause_d     = mcause_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 8'd0;
                end else if (commit_valid && commit_mret) begin
                    state_d    = ST_MRET;
                    redirect_d = mepc_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Cause and target are taken at exit so late-arriving higher priority wins.
                if (!pending_s) begin
                    state_d = ST_IDLE;
                end else if (commit_valid || (cnt_q == DRAIN_LIMIT)) begin
                    state_d      = ST_TRAP;
                    mepc_wdata_d = trap_pc_s;
                    mcause_d     = cause_s;
                    redirect_d   = target_s;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_TRAP: begin
                state_d = ST_IDLE;
            end
            ST_MRET: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched trap data.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            redirect_q   <= {XLEN{1'b0}};
            mepc_wdata_q <= {XLEN{1'b0}};
            mcause_q     <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            redirect_q   <= redirect_d;
            mepc_wdata_q <= mepc_wdata_d;
            mcause_q     <= mcause_d;
        end
    end

    assign stall_req      = (state_q != ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign flush          = (state_q == ST_TRAP) || (state_q == ST_MRET);
    assign redirect_valid = (state_q == ST_TRAP) || (state_q == ST_MRET);
    assign trap_we        = (state_q == ST_TRAP);
    assign mstatus_trap   = (state_q == ST_TRAP);
    assign mstatus_mret   = (state_q == ST_MRET);
    assign redirect_pc    = redirect_q;
    assign mepc_wdata     = mepc_wdata_q;
    assign mcause_wdata   = mcause_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with hand-computed expectations.
module tb_trap_controller;

    logic        clk;
    logic        reset;
    logic        irq_timer, irq_ext, mie_mtie, mie_meie, mstatus_mie;
    logic [31:0] mtvec, mepc_q, commit_pc, fetch_pc;
    logic        commit_valid, commit_mret;
    logic        stall_req, flush, redirect_valid, trap_we, mstatus_trap, mstatus_mret, busy;
    logic [31:0] redirect_pc, mepc_wdata, mcause_wdata;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    trap_controller #(.XLEN(32), .DRAIN_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .irq_timer(irq_timer), .irq_ext(irq_ext),
        .mie_mtie(mie_mtie), .mie_meie(mie_meie), .mstatus_mie(mstatus_mie),
        .mtvec(mtvec), .mepc_q(mepc_q),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_mret(commit_mret),
        .fetch_pc(fetch_pc),
        .stall_req(stall_req), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_we(trap_we),
        .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata),
        .mstatus_trap(mstatus_trap), .mstatus_mret(mstatus_mret), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq_timer = 1'b0; irq_ext = 1'b0; mie_mtie = 1'b0; mie_meie = 1'b0;
        mstatus_mie = 1'b0; commit_valid = 1'b0; commit_mret = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        mtvec = 32'h0; mepc_q = 32'h0; commit_pc = 32'h0; fetch_pc = 32'h0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_stall", {31'd0, stall_req}, 32'd0);
        check_eq("rst_flush", {31'd0, flush}, 32'd0);
        check_eq("rst_trap_we", {31'd0, trap_we}, 32'd0);
        check_eq("rst_mepc", mepc_wdata, 32'h0);
        check_eq("rst_mcause", mcause_wdata, 32'h0);
        check_eq("rst_redir", redirect_pc, 32'h0);

        // Timer entry, direct mode, commit two cycles later
        mtvec = 32'h100; mstatus_mie = 1'b1; mie_mtie = 1'b1; irq_timer = 1'b1;
        tick();
        check_eq("t1_stall", {31'd0, stall_req}, 32'd1);
        check_eq("t1_drain_flush", {31'd0, flush}, 32'd0);
        tick();
        commit_valid = 1'b1; commit_pc = 32'h40;
        tick();
        clear_inputs();
        check_eq("t1_trap_we", {31'd0, trap_we}, 32'd1);
        check_eq("t1_mepc", mepc_wdata, 32'h40);
        check_eq("t1_mcause", mcause_wdata, 32'h80000007);
        check_eq("t1_redir", redirect_pc, 32'h100);
        check_eq("t1_mstatus_trap", {31'd0, mstatus_trap}, 32'd1);
        check_eq("t1_flush", {31'd0, flush}, 32'd1);
        check_eq("t1_rvalid", {31'd0, redirect_valid}, 32'd1);
        tick();
        check_eq("t1_after_flush", {31'd0, flush}, 32'd0);
        check_eq("t1_after_busy", {31'd0, busy}, 32'd0);

        // Vectored mode, external beats timer
        mtvec = 32'h201; mstatus_mie = 1'b1; mie_mtie = 1'b1; mie_meie = 1'b1;
        irq_timer = 1'b1; irq_ext = 1'b1;
        tick();
        commit_valid = 1'b1; commit_pc = 32'h1000;
        tick();
        clear_inputs();
        check_eq("t2_mcause", mcause_wdata, 32'h8000000B);
        check_eq("t2_redir", redirect_pc, 32'h22C);
        check_eq("t2_mepc", mepc_wdata, 32'h1000);
        tick();
        check_eq("t2_after_busy", {31'd0, busy}, 32'd0);

        // mret
        mepc_q = 32'h44; commit_valid = 1'b1; commit_mret = 1'b1; commit_pc = 32'h500;
        tick();
        clear_inputs();
        check_eq("t3_mret", {31'd0, mstatus_mret}, 32'd1);
        check_eq("t3_flush", {31'd0, flush}, 32'd1);
        check_eq("t3_rvalid", {31'd0, redirect_valid}, 32'd1);
        check_eq("t3_redir", redirect_pc, 32'h44);
        check_eq("t3_trap_we", {31'd0, trap_we}, 32'd0);
        tick();
        check_eq("t3_busy", {31'd0, busy}, 32'd0);
        check_eq("t3_flush2", {31'd0, flush}, 32'd0);

        // Drain timeout with DRAIN_MAX=3
        mtvec = 32'h100; fetch_pc = 32'h80; mstatus_mie = 1'b1; mie_mtie = 1'b1; irq_timer = 1'b1;
        cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (trap_we) begin
                cycles = i;
                clear_inputs();
                break;
            end
        end
        check_eq("t4_latency", cycles, 32'd5);
        check_eq("t4_mepc", mepc_wdata, 32'h80);
        check_eq("t4_mcause", mcause_wdata, 32'h80000007);
        clear_inputs();
        tick();

        // Abort: interrupt drops while draining
        mstatus_mie = 1'b1; mie_mtie = 1'b1; irq_timer = 1'b1;
        tick();
        tick();
        irq_timer = 1'b0;
        tick();
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_trap_we", {31'd0, trap_we}, 32'd0);
        tick();
        check_eq("t5_trap_we2", {31'd0, trap_we}, 32'd0);
        check_eq("t5_mepc_kept", mepc_wdata, 32'h80);
        clear_inputs();

        // Collision: interrupt and mret commit in the same IDLE cycle
        mepc_q = 32'h44; mstatus_mie = 1'b1; mie_mtie = 1'b1; irq_timer = 1'b1;
        commit_valid = 1'b1; commit_mret = 1'b1; commit_pc = 32'h300;
        tick();
        check_eq("t6_no_mret", {31'd0, mstatus_mret}, 32'd0);
        check_eq("t6_stall", {31'd0, stall_req}, 32'd1);
        check_eq("t6_no_flush", {31'd0, flush}, 32'd0);
        tick();
        clear_inputs();
        check_eq("t6_trap_we", {31'd0, trap_we}, 32'd1);
        check_eq("t6_mepc", mepc_wdata, 32'h300);
        check_eq("t6_no_mret2", {31'd0, mstatus_mret}, 32'd0);
        tick();

        // Reset asserted during TRAP
        mtvec = 32'h100; mstatus_mie = 1'b1; mie_mtie = 1'b1; irq_timer = 1'b1;
        tick();
        commit_valid = 1'b1; commit_pc = 32'h60;
        tick();
        clear_inputs();
        check_eq("t7_in_trap", {31'd0, trap_we}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check_eq("t7_rst_trap_we", {31'd0, trap_we}, 32'd0);
        check_eq("t7_rst_flush", {31'd0, flush}, 32'd0);
        check_eq("t7_rst_rvalid", {31'd0, redirect_valid}, 32'd0);
        check_eq("t7_rst_mstatus", {31'd0, mstatus_trap}, 32'd0);
        check_eq("t7_rst_stall", {31'd0, stall_req}, 32'd0);
        check_eq("t7_rst_mepc", mepc_wdata, 32'h0);
        check_eq("t7_rst_redir", redirect_pc, 32'h0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check_eq("t7_rel_busy", {31'd0, busy}, 32'd0);
        check_eq("t7_rel_trap_we", {31'd0, trap_we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
